// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// The state encoding is fixed at 2 bits.
// SEL_W matches the ShiftSel input of the external 0..3 barrel shifter.
package shift_seq_pkg;

   localparam int unsigned STEP_MAX = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Largest step the shifter can take toward the remaining amount.
   function automatic logic [SEL_W-1:0] step_amt(input int unsigned remain);
      if (remain > STEP_MAX)
         return SEL_W'(STEP_MAX);
      else
         return SEL_W'(remain);
   endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Multi-cycle controller that drives an external 0..3-position left
// shifter to realise left shifts of 0..2^AMT_W-1 positions.
// Each step shifts by min(remain, STEP_MAX), and the result is fed back.
// Optional macro SHIFT_SEQ_OVF_EN adds a sticky out_ovf output.
// out_ovf reports whether any 1 bit was shifted past the MSB.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_operand,
   input  logic [AMT_W-1:0] in_amount,
   output logic [SEL_W-1:0] sh_sel,
   output logic [WIDTH-1:0] sh_operand,
   input  logic [WIDTH-1:0] sh_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
`ifdef SHIFT_SEQ_OVF_EN
   output logic             out_ovf,
`endif
   output logic             out_busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_work;
   logic [AMT_W-1:0] r_remain;
   logic [AMT_W-1:0] w_remain_nxt;
   logic [SEL_W-1:0] w_step;
   logic             w_accept;

   assign sh_sel     = w_step;
   assign sh_operand = r_work;
   assign out_result = r_work;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic, handshake outputs and the per-step shift amount.
   always_comb begin
      w_state_nxt  = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_busy     = 1'b0;
      w_accept     = 1'b0;
      w_step       = '0;
      w_remain_nxt = r_remain;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = (in_amount == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            out_busy     = 1'b1;
            w_step       = step_amt(32'(r_remain));
            w_remain_nxt = r_remain - AMT_W'(w_step);
            if (w_remain_nxt == '0)
               w_state_nxt = DONE;
         end
         DONE: begin
            out_busy  = 1'b1;
            out_valid = 1'b1;
            if (out_ready)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Working value and remaining amount: load on accept, then iterate.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_work   <= '0;
         r_remain <= '0;
      end else if (w_accept) begin
         r_work   <= in_operand;
         r_remain <= in_amount;
      end else if (r_state == SHIFT) begin
         r_work   <= sh_result;
         r_remain <= w_remain_nxt;
      end
   end

`ifdef SHIFT_SEQ_OVF_EN
   logic r_ovf;
   logic w_lost;

   // The top w_step bits of work leave the word during this step.
   assign w_lost  = (w_step != '0) &&
                    ((r_work >> (WIDTH - 32'(w_step))) != '0);
   assign out_ovf = r_ovf;

   // Sticky overflow flag: cleared on accept, accumulates during SHIFT.
   always_ff @(posedge clk) begin
      if (!reset_n)
         r_ovf <= 1'b0;
      else if (w_accept)
         r_ovf <= 1'b0;
      else if (r_state == SHIFT)
         r_ovf <= r_ovf | w_lost;
   end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer.
// A behavioural 0..3 left shifter is placed alongside the DUT.
// Overflow checks are active only when SHIFT_SEQ_OVF_EN is defined.
module tb_shift_sequencer;
   import shift_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_operand;
   logic [3:0]  in_amount;
   logic [1:0]  sh_sel;
   logic [15:0] sh_operand;
   logic [15:0] sh_result;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_busy;
`ifdef SHIFT_SEQ_OVF_EN
   logic        out_ovf;
`endif

   int vectors     = 0;
   int miscompares = 0;

   shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_operand (in_operand),
      .in_amount  (in_amount),
      .sh_sel     (sh_sel),
      .sh_operand (sh_operand),
      .sh_result  (sh_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
`ifdef SHIFT_SEQ_OVF_EN
      .out_ovf    (out_ovf),
`endif
      .out_busy   (out_busy)
   );

   // External four-way shifter: zero fill, bits past bit 15 dropped.
   assign sh_result = sh_operand << sh_sel;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request: sels holds the hand-computed sh_sel sequence, LSB first.
   task automatic do_op(input logic [15:0] op, input logic [3:0] amt,
                        input logic [15:0] exp_res, input int steps,
                        input logic [9:0] sels, input logic exp_ovf,
                        input int stall);
      int          cyc;
      logic [15:0] model;
      in_operand = op;
      in_amount  = amt;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc   = 1;
      model = op;
      while (out_valid !== 1'b1 && cyc <= 20) begin
         if (cyc <= steps) begin
            check("sh_sel", 32'(sh_sel), 32'(sels[2*(cyc-1) +: 2]));
            check("sh_operand", 32'(sh_operand), 32'(model));
            check("in_ready_shift", 32'(in_ready), 32'd0);
            model = model << sels[2*(cyc-1) +: 2];
         end
         @(negedge clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'(steps + 1));
      check("out_result", 32'(out_result), 32'(exp_res));
      check("sh_sel_done", 32'(sh_sel), 32'd0);
      check("busy_done", 32'(out_busy), 32'd1);
`ifdef SHIFT_SEQ_OVF_EN
      check("out_ovf", 32'(out_ovf), 32'(exp_ovf));
`else
      if (exp_ovf) begin end
`endif
      for (int i = 0; i < stall; i++) begin
         in_valid   = 1'b1;
         in_operand = 16'hFFFF;
         in_amount  = 4'd5;
         @(negedge clk);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_result", 32'(out_result), 32'(exp_res));
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_busy", 32'(out_busy), 32'd0);
   endtask

   initial begin
      int seen;
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_operand = '0;
      in_amount  = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'd0);
      check("rst_sh_sel", 32'(sh_sel), 32'd0);
      check("rst_sh_operand", 32'(sh_operand), 32'd0);
      check("rst_busy", 32'(out_busy), 32'd0);
`ifdef SHIFT_SEQ_OVF_EN
      check("rst_ovf", 32'(out_ovf), 32'd0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a 9-position shift.
      in_operand = 16'h00FF;
      in_amount  = 4'd9;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_sel1", 32'(sh_sel), 32'd3);
      @(negedge clk);
      check("mid_op2", 32'(sh_operand), 32'h07F8);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_in_ready", 32'(in_ready), 32'd1);
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_work", 32'(sh_operand), 32'd0);
      reset_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      out_ready = 1'b0;
      check("mid_no_result", 32'(seen), 32'd0);

      // op, amount, result, steps, sh_sel sequence (LSB first), ovf, stall
      do_op(16'h0001, 4'd7,  16'h0080, 3, 10'b00_00_01_11_11, 1'b0, 0);
      do_op(16'hABCD, 4'd0,  16'hABCD, 0, 10'b00_00_00_00_00, 1'b0, 0);
      do_op(16'h8001, 4'd15, 16'h8000, 5, 10'b11_11_11_11_11, 1'b1, 0);
      do_op(16'h1234, 4'd4,  16'h2340, 2, 10'b00_00_00_01_11, 1'b1, 3);
      do_op(16'h0003, 4'd2,  16'h000C, 1, 10'b00_00_00_00_10, 1'b0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
